debounce_sync: RTL and testbench
================================

// Module: debounce_sync
// PURPOSE
//   Front-end conditioner for asynchronous, bouncy single-bit inputs such as buttons and switches.
//   It synchronises the raw input into the clk domain and debounces it with a consecutive-sample counter.
//   It produces a clean level plus one-cycle rise/fall pulses.
//   It sits directly upstream of posedge_detector-style consumers; data_out is safe to feed any edge detector.
// PARAMETERS
//   SYNC_STAGES      2   flops in synchroniser chain; legal >= 2
//   DEBOUNCE_CYCLES  16  consecutive mismatching samples required to commit a change; legal >= 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES) (localparam) counter width
// PORTS
//   clk         in   1  system clock, all logic on posedge
//   rst_n       in   1  asynchronous active-low reset
//   data_in     in   1  raw asynchronous input; no timing relationship to clk
//   data_out    out  1  debounced, synchronised level
//   rise_pulse  out  1  1-cycle high when data_out goes 0->1
//   fall_pulse  out  1  1-cycle high when data_out goes 1->0
//   busy        out  1  high while a candidate change is being verified (FSM in VERIFY)
// BEHAVIOUR
//   Reset (rst_n low, async assert, sync release via normal flops):
//     - Sync chain, counter, data_out, rise_pulse, fall_pulse and busy all reset to 0.
//     - FSM resets to STABLE.
//   Synchroniser:
//     - sync_q is the output of a SYNC_STAGES-deep flop chain on data_in.
//     - A level sampled at edge 1 appears on sync_q after edge SYNC_STAGES.
//   FSM, two states:
//     - STABLE: counter = 0, busy = 0.
//       - If sync_q != data_out: go to VERIFY, counter <= 1.
//     - VERIFY: busy = 1.
//       - If sync_q == data_out (bounce back): go to STABLE, counter <= 0. No output change, no pulse.
//       - Else if counter == DEBOUNCE_CYCLES-1: data_out <= sync_q, fire the matching pulse, go to STABLE, counter <= 0.
//       - Else: counter <= counter + 1.
//   Latency:
//     - A clean step on data_in held steady appears on data_out exactly SYNC_STAGES + DEBOUNCE_CYCLES edges after the first sampling edge.
//     - At defaults this is 18 cycles.
//   Pulses:
//     - Registered and asserted in the same cycle data_out changes. High for exactly one cycle.
//     - rise_pulse and fall_pulse are never both high.
//   Counter:
//     - Never exceeds DEBOUNCE_CYCLES-1 and never wraps.
//   Boundary conditions:
//     - Glitch shorter than DEBOUNCE_CYCLES consecutive synced samples: fully rejected, no pulse.
//     - Mismatch lasting exactly DEBOUNCE_CYCLES samples: commits.
//     - Mismatch lasting DEBOUNCE_CYCLES-1 samples: rejected.
//     - Toggle back in the commit cycle is impossible, because commit uses the sample already compared.
//     - Reset asserted mid-VERIFY: abort immediately. Outputs go to 0 with no pulse.
//     - data_in high at reset release: treated as a normal 0->1 change. rise_pulse fires after full latency.
//     - Two changes back-to-back: each requires a full fresh DEBOUNCE_CYCLES window, starting the cycle after the commit.
// STRUCTURE
//   Package debounce_pkg:
//     - typedef enum logic {ST_STABLE, ST_VERIFY} db_state_t.
//     - Default constants DB_SYNC_STAGES = 2 and DB_DEBOUNCE_CYCLES = 16.
//   Sub-module sync_ff_chain:
//     - Parameter STAGES. Ports clk, rst_n, d, q.
//     - Reset value 0. Mark ASYNC_REG on its flops.
//   Top-level contents: FSM, counter, output/pulse registers.
//   No combinational path from data_in to any output.
// TESTING (defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=16)
//   1. Reset then hold data_in=0 for 100 cycles
//      -> data_out, rise_pulse, fall_pulse and busy all stay 0.
//   2. Clean step 0->1 at cycle 10
//      -> data_out=1 and rise_pulse=1 exactly at cycle 28, rise_pulse=0 at cycle 29.
//      -> busy high cycles 13..27.
//   3. Bounce: data_in high 5 cycles, low 3, high 10, then low
//      -> data_out stays 0, no pulses, busy returns to 0.
//   4. Width edges: high for exactly 16 synced cycles -> commits; high for 15 -> rejected.
//      - Repeat for 1->0 and check fall_pulse.
//   5. rst_n low for 2 cycles during VERIFY (counter=8)
//      -> all outputs 0 asynchronously, no pulse.
//      - With data_in held 1, rise_pulse fires 18 cycles after release.
//   6. Random bounce stress, 10k cycles
//      -> pulse count matches reference model, pulses never overlap, counter <= 15.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default constants for the input debouncer.
package debounce_pkg;

    // Two-state debounce FSM: idle/committed vs. counting a candidate change.
    typedef enum logic {
        ST_STABLE,
        ST_VERIFY
    } db_state_t;

    localparam int unsigned DB_SYNC_STAGES     = 2;
    localparam int unsigned DB_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for a single asynchronous bit; resets to 0.
module sync_ff_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_q;

    // Shift the raw input through the chain; the first flop may go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise and debounce a bouncy asynchronous input; emit a clean level plus
// single-cycle rise/fall pulses. All outputs come straight from flops.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DB_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DB_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic data_in,
    output logic data_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_q, data_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (data_in),
        .q     (sync_q)
    );

    // Next-state: count consecutive mismatching samples, commit on the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync_q != data_q) begin
                    state_d = ST_VERIFY;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_VERIFY: begin
                if (sync_q == data_q) begin
                    // Bounced back before the window filled: drop the candidate.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Commit the very sample just compared, so no toggle-back race.
                    data_d  = sync_q;
                    rise_d  = sync_q;
                    fall_d  = ~sync_q;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset aborts any pending change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            data_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign data_out   = data_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = (state_q == ST_VERIFY);

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: a run-length reference model pushes the
// expected outputs every clock; they are popped and compared on the falling edge.
module tb_debounce_sync;

    localparam int SYNC = 2;
    localparam int DEB  = 16;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic data_in = 1'b0;
    logic data_out, rise_pulse, fall_pulse, busy;

    debounce_sync #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_out   (data_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];
    int m_rise = 0, m_fall = 0, d_rise = 0, d_fall = 0;
    int overlap = 0, max_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: sync delay line, then count consecutive mismatches against the
    // committed level; a full window of DEB mismatches commits.
    initial begin : model
        logic [SYNC-1:0] sh;
        logic out, s, r, f;
        int run;
        sh  = '0;
        out = 1'b0;
        run = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                sh  = '0;
                out = 1'b0;
                run = 0;
                exp_q.delete();
            end else begin
                s  = sh[SYNC-1];
                sh = {sh[SYNC-2:0], data_in};
                r  = 1'b0;
                f  = 1'b0;
                if (s != out) begin
                    run++;
                    if (run == DEB) begin
                        out = s;
                        r   = s;
                        f   = ~s;
                        run = 0;
                    end
                end else begin
                    run = 0;
                end
                exp_q.push_back({out, r, f, (run != 0)});
            end
        end
    end

    initial begin : scoreboard
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs{out,rise,fall,busy}",
                      int'({data_out, rise_pulse, fall_pulse, busy}), int'(e));
                m_rise += int'(e[2]);
                m_fall += int'(e[1]);
                d_rise += int'(rise_pulse);
                d_fall += int'(fall_pulse);
                if (rise_pulse && fall_pulse) overlap++;
                if (int'(dut.cnt_q) > max_cnt) max_cnt = int'(dut.cnt_q);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic v, input int n);
        data_in = v;
        cycles(n);
    endtask

    // Apply a step and count falling edges until data_out follows (bounded).
    task automatic latency(input string tag, input logic v);
        int n;
        n = 0;
        data_in = v;
        while (data_out !== v && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, SYNC + DEB);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int r0, f0, total;
        cycles(3);
        check("reset_outputs", int'({data_out, rise_pulse, fall_pulse, busy}), 0);
        rst_n = 1'b1;

        // Idle low input
        drive(1'b0, 100);
        check("idle_no_rise", d_rise, 0);
        check("idle_no_fall", d_fall, 0);

        // Clean rising step
        latency("rise_latency", 1'b1);
        check("rise_pulse_at_commit", int'(rise_pulse), 1);
        cycles(1);
        check("rise_pulse_one_cycle", int'(rise_pulse), 0);
        cycles(5);

        // Clean falling step, then a bounce burst that must be rejected
        latency("fall_latency", 1'b0);
        check("fall_pulse_at_commit", int'(fall_pulse), 1);
        cycles(5);
        r0 = d_rise;
        drive(1'b1, 5);
        drive(1'b0, 3);
        drive(1'b1, 10);
        drive(1'b0, 30);
        check("bounce_no_rise", d_rise - r0, 0);
        check("bounce_out_low", int'(data_out), 0);
        check("bounce_busy_idle", int'(busy), 0);

        // Width boundaries 0->1
        r0 = d_rise;
        drive(1'b1, DEB);
        drive(1'b0, 40);
        check("width_full_rise", d_rise - r0, 1);
        r0 = d_rise;
        drive(1'b1, DEB - 1);
        drive(1'b0, 40);
        check("width_short_rise", d_rise - r0, 0);

        // Width boundaries 1->0
        drive(1'b1, 30);
        f0 = d_fall;
        drive(1'b0, DEB);
        drive(1'b1, 40);
        check("width_full_fall", d_fall - f0, 1);
        f0 = d_fall;
        drive(1'b0, DEB - 1);
        drive(1'b1, 40);
        check("width_short_fall", d_fall - f0, 0);
        check("width_out_high", int'(data_out), 1);

        // Reset mid-VERIFY
        drive(1'b0, 30);
        data_in = 1'b1;
        cycles(10);
        check("cnt_before_reset", int'(dut.cnt_q), 8);
        #2 rst_n = 1'b0;
        #1 check("reset_async_outputs",
                 int'({data_out, rise_pulse, fall_pulse, busy}), 0);
        cycles(2);
        rst_n = 1'b1;
        latency("release_rise_latency", 1'b1);
        check("release_rise_pulse", int'(rise_pulse), 1);

        // Random bounce stress
        total = 0;
        while (total < 10000) begin
            int n;
            n = $urandom_range(1, 24);
            drive(1'($urandom_range(0, 1)), n);
            total += n;
        end
        drive(1'b0, 40);
        check("stress_rise_count", d_rise, m_rise);
        check("stress_fall_count", d_fall, m_fall);
        check("pulse_overlap", overlap, 0);
        check("cnt_bounded", int'(max_cnt <= DEB - 1), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
